// File: rtl/exp_golomb_decode_if.sv
// ---------------------------------------------------------------------------
// exp_golomb_decode_if
// Handshake bundle for the bit-serial exp-Golomb decoder.
//   Input side : k, is_ac_level, in_valid, in_bit -> ; <- in_ready
//   Output side: out_valid, val, is_minus, codeword_length, error -> ;
//                <- out_ready
// modport slave  : the decoder
// modport master : the producer/consumer driving the decoder
// ---------------------------------------------------------------------------
interface exp_golomb_decode_if;
    logic [2:0]  k;
    logic        is_ac_level;
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] val;
    logic        is_minus;
    logic [31:0] codeword_length;
    logic        error;

    modport slave (
        input  k, is_ac_level, in_valid, in_bit, out_ready,
        output in_ready, out_valid, val, is_minus, codeword_length, error
    );

    modport master (
        output k, is_ac_level, in_valid, in_bit, out_ready,
        input  in_ready, out_valid, val, is_minus, codeword_length, error
    );
endinterface

// File: rtl/exp_golomb_decode.sv
// ---------------------------------------------------------------------------
// exp_golomb_decode
// Bit-serial exponential-Golomb decoder. One codeword bit is accepted per
// cycle (in_valid && in_ready); the zero prefix is counted, the suffix
// gathered MSB-first and, in AC-level mode, a trailing sign bit taken.
// The result is held on out_valid until out_ready.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : exp_golomb_decode_if.slave (k, is_ac_level, in_valid, in_bit,
//           in_ready, out_valid, out_ready, val, is_minus,
//           codeword_length, error)
// Parameter MAX_PREFIX: largest legal zero-prefix count (<= 24 keeps the
// 32-bit accumulator from overflowing with k up to 7).
// Macro EXP_GOLOMB_DECODE_SIGN_EN: builds the SIGN state and honours
// is_ac_level; otherwise is_minus is 0 and is_ac_level is ignored.
// ---------------------------------------------------------------------------
module exp_golomb_decode #(
    parameter int unsigned MAX_PREFIX = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    exp_golomb_decode_if.slave       bus
);
`ifdef EXP_GOLOMB_DECODE_SIGN_EN
    typedef enum logic [1:0] {PREFIX, SUFFIX, SIGN, OUT} state_t;
`else
    typedef enum logic [1:0] {PREFIX, SUFFIX, OUT} state_t;
`endif

    localparam logic [5:0] LP_MAXP = 6'(MAX_PREFIX);

    state_t      r_state, w_next;
    logic [5:0]  r_zcnt;
    logic [5:0]  r_rem;
    logic [31:0] r_acc;
    logic [2:0]  r_k;
    logic [31:0] r_val;
    logic [31:0] r_len;
    logic        r_error;

    logic        w_accept;
    logic [2:0]  w_k_eff;
    logic        w_ac_eff;
    logic [31:0] w_acc_next;
    logic [5:0]  w_rem_start;
    logic [31:0] w_val_fin;
    logic [31:0] w_len_fin;

    // The first accepted bit of a codeword must already use the port values
    // of k / is_ac_level, since the latched copies are written on that edge.
`ifdef EXP_GOLOMB_DECODE_SIGN_EN
    logic r_ac;
    logic r_minus;
    assign w_ac_eff = (r_state == PREFIX && r_zcnt == '0) ? bus.is_ac_level : r_ac;
    assign bus.is_minus = r_minus;
`else
    logic w_unused_ac;
    assign w_unused_ac  = bus.is_ac_level;
    assign w_ac_eff     = 1'b0;
    assign bus.is_minus = 1'b0;
`endif

    assign w_k_eff     = (r_state == PREFIX && r_zcnt == '0) ? bus.k : r_k;
    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_acc_next  = (r_state == PREFIX) ? 32'd1 : {r_acc[30:0], bus.in_bit};
    assign w_rem_start = r_zcnt + {3'b000, w_k_eff};
    assign w_val_fin   = w_acc_next - (32'd1 << w_k_eff);
    assign w_len_fin   = ({26'd0, r_zcnt} << 1) + {29'd0, w_k_eff} + 32'd1
                       + {31'd0, w_ac_eff};

    assign bus.in_ready        = !reset && (r_state != OUT);
    assign bus.out_valid       = (r_state == OUT);
    assign bus.val             = r_val;
    assign bus.codeword_length = r_len;
    assign bus.error           = r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= PREFIX;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            PREFIX: if (w_accept) begin
                if (!bus.in_bit) begin
                    if (r_zcnt == LP_MAXP) w_next = OUT;
                end else if (w_rem_start == '0) begin
`ifdef EXP_GOLOMB_DECODE_SIGN_EN
                    w_next = w_ac_eff ? SIGN : OUT;
`else
                    w_next = OUT;
`endif
                end else begin
                    w_next = SUFFIX;
                end
            end
            SUFFIX: if (w_accept && r_rem == 6'd1) begin
`ifdef EXP_GOLOMB_DECODE_SIGN_EN
                w_next = w_ac_eff ? SIGN : OUT;
`else
                w_next = OUT;
`endif
            end
`ifdef EXP_GOLOMB_DECODE_SIGN_EN
            SIGN:   if (w_accept) w_next = OUT;
`endif
            OUT:    if (bus.out_ready) w_next = PREFIX;
            default: w_next = PREFIX;
        endcase
    end

    // Result registers are loaded when the last suffix bit (or the lone '1')
    // arrives, so SIGN only has to supply is_minus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zcnt  <= '0;
            r_rem   <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            r_val   <= '0;
            r_len   <= '0;
            r_error <= 1'b0;
`ifdef EXP_GOLOMB_DECODE_SIGN_EN
            r_ac    <= 1'b0;
            r_minus <= 1'b0;
`endif
        end else begin
            case (r_state)
                PREFIX: if (w_accept) begin
                    if (r_zcnt == '0) begin
                        r_k  <= bus.k;
`ifdef EXP_GOLOMB_DECODE_SIGN_EN
                        r_ac <= bus.is_ac_level;
`endif
                    end
                    if (!bus.in_bit) begin
                        r_zcnt <= r_zcnt + 6'd1;
                        if (r_zcnt == LP_MAXP) begin
                            r_error <= 1'b1;
                            r_val   <= '0;
                            r_len   <= {26'd0, r_zcnt} + 32'd1;
                        end
                    end else begin
                        r_acc <= w_acc_next;
                        r_rem <= w_rem_start;
                        if (w_rem_start == '0) begin
                            r_val <= w_val_fin;
                            r_len <= w_len_fin;
                        end
                    end
                end
                SUFFIX: if (w_accept) begin
                    r_acc <= w_acc_next;
                    r_rem <= r_rem - 6'd1;
                    if (r_rem == 6'd1) begin
                        r_val <= w_val_fin;
                        r_len <= w_len_fin;
                    end
                end
`ifdef EXP_GOLOMB_DECODE_SIGN_EN
                SIGN: if (w_accept) r_minus <= bus.in_bit;
`endif
                OUT: if (bus.out_ready) begin
                    r_zcnt  <= '0;
                    r_acc   <= '0;
                    r_error <= 1'b0;
`ifdef EXP_GOLOMB_DECODE_SIGN_EN
                    r_minus <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
